pulsemeter_mc: RTL and testbench
================================

PULSEMETER_MC -- requirements
Module: pulsemeter_mc

Interface
REQ-001 Parameter NCH, default 4: number of pulse input channels, legal range 1..8.
REQ-002 Parameter CNT_W, default 16: per-channel counter width, legal range 8..32.
REQ-003 Parameter DB_LEN, default 16: clk cycles an input must be stable to be accepted, legal range 2..255.
REQ-004 Parameter SAT, default 0: 1 = counters saturate at all-ones; 0 = counters wrap to 0.
REQ-005 Port clk, input, 1: single system clock; all logic is clocked on its rising edge.
REQ-006 Port rst, input, 1: reset, synchronous and active-high.
REQ-007 Port spi_clk, input, 1: SPI mode-0 clock, asynchronous to clk.
REQ-008 Port spi_csn, input, 1: SPI chip select, active low.
REQ-009 Port spi_mosi, input, 1: SPI data from host.
REQ-010 Port spi_miso, output, 1: SPI data to host.
REQ-011 Port pulse_in, input, NCH: raw asynchronous pulse inputs.
REQ-012 Port led_n, output, 2: active-low LED drive.

Function
REQ-013 spi_clk, spi_csn, spi_mosi and each pulse_in bit SHALL pass through a 2-FF synchronizer to clk before use.
REQ-014 Each channel SHALL count one event per accepted rising edge: synchronized input high for DB_LEN consecutive cycles after having been accepted low; accepted low requires DB_LEN consecutive low cycles.
REQ-015 An accepted edge SHALL produce exactly one single-cycle pulse; the counter increments on the cycle after that pulse.
REQ-016 With SAT=0 the counter SHALL wrap from all-ones to 0; with SAT=1 it SHALL hold at all-ones.
REQ-017 Start of transaction (sot) SHALL be a synchronized spi_csn 1->0 transition; end of transaction (eot) SHALL be a synchronized spi_csn 0->1 transition.
REQ-018 On sot, all counters SHALL be copied into a shadow frame and cleared in the same cycle; a channel pulse in the sot cycle SHALL load that counter with 1, not 0, so no pulse is lost.
REQ-019 Frame layout SHALL be NCH*CNT_W bits: channel 0 first, each channel MSB first.
REQ-020 spi_miso SHALL present frame bit 0 on sot, then advance one bit on each synchronized spi_clk falling edge; bits past the end of the frame SHALL read 0.
REQ-021 While spi_csn is high, spi_miso SHALL be 0.
REQ-022 spi_mosi SHALL be sampled on each synchronized spi_clk rising edge into an 8-bit shift register, MSB first.
REQ-023 On eot, if at least 8 bits were received, ctrl SHALL latch the first 8 received bits; otherwise ctrl SHALL be unchanged.
REQ-024 led_n SHALL equal ~ctrl[1:0].
REQ-025 A sot with no eot before a further sot is impossible by construction; a csn glitch shorter than 3 clk cycles SHALL be treated as a complete sot/eot pair.
REQ-026 Counting SHALL continue without interruption during a transaction.

Reset
REQ-027 While rst is high: all counters, the shadow frame, debounce state (accepted level 0) and ctrl SHALL clear; led_n SHALL be 2'b11; spi_miso SHALL be 0.
REQ-028 rst asserted mid-transaction SHALL abort it; the host reads 0s until the next sot, and the following eot SHALL NOT update ctrl.

Configuration
REQ-029 Macro PULSEMETER_OVF_FLAG_EN defined: each channel SHALL have a sticky overflow flag, set when the counter wraps or saturates and cleared at sot. An NCH-bit field of these flags, captured at sot, SHALL be appended after the counter data, channel 0 first.
REQ-030 Macro PULSEMETER_OVF_FLAG_EN undefined: no overflow flags exist and the frame is NCH*CNT_W bits.

Structure
REQ-031 Package pulsemeter_pkg SHALL hold the frame-length function, the ctrl bit index constants (LED0=0, LED1=1) and the parameter limit constants.
REQ-032 The per-channel synchronizer, debouncer and counter SHALL be one sub-module, pm_channel, instantiated NCH times via generate; SPI logic SHALL stay in the top level.

Verification
REQ-033 NCH=4, DB_LEN=4: 5 clean pulses on ch2, then a 32-bit read -> ch2 field=5, others 0; a second read returns all 0.
REQ-034 Pulse on ch0 with its accepted edge in the sot cycle -> current read excludes it; the next read returns ch0=1.
REQ-035 A 2-cycle glitch on ch1 with DB_LEN=4 -> count stays 0.
REQ-036 CNT_W=8: 257 pulses -> SAT=0 reads 1; SAT=1 reads 255; with PULSEMETER_OVF_FLAG_EN the flag bit for that channel is 1.
REQ-037 MOSI 0x02 over 8 bits -> led_n=2'b01 after eot; a 5-bit transfer leaves led_n unchanged.
REQ-038 rst pulsed mid-read -> the rest of the read is 0s; led_n=2'b11; counters restart from 0.

Source files
------------

// File: rtl/pulsemeter_pkg.sv
// Shared constants, SPI transaction state type and frame-length helper for pulsemeter_mc.
// PULSEMETER_OVF_FLAG_EN adds a per-channel overflow flag field to the frame.
package pulsemeter_pkg;

  localparam int NCH_MIN    = 1;
  localparam int NCH_MAX    = 8;
  localparam int CNT_W_MIN  = 8;
  localparam int CNT_W_MAX  = 32;
  localparam int DB_LEN_MIN = 2;
  localparam int DB_LEN_MAX = 255;

  localparam int LED0 = 0;
  localparam int LED1 = 1;

`ifdef PULSEMETER_OVF_FLAG_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } spi_state_t;

  function automatic int frame_len(input int nch, input int cnt_w, input bit ovf_en);
    return nch * cnt_w + (ovf_en ? nch : 0);
  endfunction

endpackage

// File: rtl/pulsemeter_mc_channel.sv
// One pulse channel: 2-FF synchronizer, symmetric debouncer and event counter.
// With PULSEMETER_OVF_FLAG_EN a sticky overflow flag is also kept.
module pm_channel
  import pulsemeter_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int DB_LEN = 16,
  parameter int SAT    = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pulse_raw,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
`ifdef PULSEMETER_OVF_FLAG_EN
  ,
  output logic             ovf
`endif
);

  localparam int        TW        = $clog2(DB_LEN_MAX + 1);
  localparam logic [TW-1:0] DB_RELOAD = TW'(DB_LEN - 1);

  logic [1:0]    sync_q;
  logic          acc_q;
  logic [TW-1:0] timer_q;
  logic          rise_q;
  logic          at_max;

  // Timer counts down while the synchronized level differs from the accepted one.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= 2'b00;
      acc_q   <= 1'b0;
      timer_q <= DB_RELOAD;
      rise_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], pulse_raw};
      rise_q <= 1'b0;
      if (sync_q[1] == acc_q) begin
        timer_q <= DB_RELOAD;
      end else if (timer_q == '0) begin
        acc_q   <= sync_q[1];
        rise_q  <= sync_q[1];
        timer_q <= DB_RELOAD;
      end else begin
        timer_q <= timer_q - TW'(1);
      end
    end
  end

  assign at_max = &cnt;

  // A pulse landing in the clear cycle seeds the fresh count so it is not lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= CNT_W'(rise_q);
    end else if (rise_q) begin
      if (!(at_max && SAT != 0)) cnt <= cnt + CNT_W'(1);
    end
  end

`ifdef PULSEMETER_OVF_FLAG_EN
  always_ff @(posedge clk) begin
    if (rst || clr) ovf <= 1'b0;
    else if (rise_q && at_max) ovf <= 1'b1;
  end
`endif

endmodule

// File: rtl/pulsemeter_mc.sv
// Multi-channel pulse counter with SPI frame readout and an 8-bit ctrl register.
// Define PULSEMETER_OVF_FLAG_EN to append per-channel overflow flags to the frame.
//
// state   | meaning
// ST_IDLE | no transaction; miso held at 0, sclk edges ignored
// ST_XFER | between sot and eot; frame shifts out, mosi shifts in
module pulsemeter_mc
  import pulsemeter_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int CNT_W  = 16,
  parameter int DB_LEN = 16,
  parameter int SAT    = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           spi_clk,
  input  logic           spi_csn,
  input  logic           spi_mosi,
  output logic           spi_miso,
  input  logic [NCH-1:0] pulse_in,
  output logic [1:0]     led_n
);

  localparam int FL = frame_len(NCH, CNT_W, OVF_EN);

  if (NCH < NCH_MIN || NCH > NCH_MAX || CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX ||
      DB_LEN < DB_LEN_MIN || DB_LEN > DB_LEN_MAX) begin : g_bad_param
    $error("pulsemeter_mc: parameter out of range");
  end

  logic [1:0] sclk_sync, csn_sync, mosi_sync;
  logic       sclk_d, csn_d;
  logic       sot, eot, sclk_rise, sclk_fall;

  // csn pipeline resets low so a host still holding csn low after reset cannot fake a sot.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= 2'b00;
      csn_sync  <= 2'b00;
      mosi_sync <= 2'b00;
      sclk_d    <= 1'b0;
      csn_d     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[0], spi_clk};
      csn_sync  <= {csn_sync[0], spi_csn};
      mosi_sync <= {mosi_sync[0], spi_mosi};
      sclk_d    <= sclk_sync[1];
      csn_d     <= csn_sync[1];
    end
  end

  assign sot       = csn_d & ~csn_sync[1];
  assign eot       = ~csn_d & csn_sync[1];
  assign sclk_rise = ~sclk_d & sclk_sync[1];
  assign sclk_fall = sclk_d & ~sclk_sync[1];

  logic [CNT_W-1:0] cnt [NCH];
`ifdef PULSEMETER_OVF_FLAG_EN
  logic [NCH-1:0] ovf;
`endif

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    pm_channel #(
      .CNT_W (CNT_W),
      .DB_LEN(DB_LEN),
      .SAT   (SAT)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .pulse_raw(pulse_in[g]),
      .clr      (sot),
      .cnt      (cnt[g])
`ifdef PULSEMETER_OVF_FLAG_EN
      ,
      .ovf      (ovf[g])
`endif
    );
  end

  logic [FL-1:0] frame_load;

  // Frame MSB is the first bit out: channel 0 field first, each field MSB first.
  always_comb begin
    frame_load = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      frame_load[FL-1-ch*CNT_W -: CNT_W] = cnt[ch];
`ifdef PULSEMETER_OVF_FLAG_EN
      frame_load[NCH-1-ch] = ovf[ch];
`endif
    end
  end

  spi_state_t state_q, state_d;
  logic       miso_en;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (sot) state_d = ST_XFER;
      ST_XFER: if (eot) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    miso_en = 1'b0;
    case (state_q)
      ST_XFER: miso_en = 1'b1;
      default: miso_en = 1'b0;
    endcase
  end

  logic [FL-1:0] shadow_q;
  logic [7:0]    rx_q;
  logic [3:0]    rx_cnt_q;
  logic [7:0]    ctrl_q;

  // Only the first 8 mosi bits are kept; ctrl updates only on a complete byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
      rx_q     <= '0;
      rx_cnt_q <= '0;
      ctrl_q   <= '0;
    end else if (sot) begin
      shadow_q <= frame_load;
      rx_cnt_q <= '0;
    end else if (state_q == ST_XFER) begin
      if (sclk_fall) shadow_q <= {shadow_q[FL-2:0], 1'b0};
      if (sclk_rise && rx_cnt_q < 4'd8) begin
        rx_q     <= {rx_q[6:0], mosi_sync[1]};
        rx_cnt_q <= rx_cnt_q + 4'd1;
      end
      if (eot && rx_cnt_q == 4'd8) ctrl_q <= rx_q;
    end
  end

  assign spi_miso = miso_en & shadow_q[FL-1] & ~rst;
  assign led_n    = rst ? 2'b11 : ~{ctrl_q[LED1], ctrl_q[LED0]};

endmodule

// File: tb/tb_pulsemeter_mc.sv
// Directed self-checking bench: a wrapping (SAT=0) and a saturating (SAT=1) instance share stimulus.
module tb_pulsemeter_mc;

  localparam int NCH = 4;
`ifdef PULSEMETER_OVF_FLAG_EN
  localparam int          FL   = 36;
  localparam logic [63:0] OVF3 = 64'h1;
`else
  localparam int          FL   = 32;
  localparam logic [63:0] OVF3 = 64'h0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           spi_clk = 1'b0;
  logic           spi_csn = 1'b1;
  logic           spi_mosi = 1'b0;
  logic [NCH-1:0] pulse_in = '0;
  logic           miso0, miso1;
  logic [1:0]     led0, led1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pulsemeter_mc #(.NCH(NCH), .CNT_W(8), .DB_LEN(4), .SAT(0)) dut0 (
    .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_csn(spi_csn), .spi_mosi(spi_mosi),
    .spi_miso(miso0), .pulse_in(pulse_in), .led_n(led0));

  pulsemeter_mc #(.NCH(NCH), .CNT_W(8), .DB_LEN(4), .SAT(1)) dut1 (
    .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_csn(spi_csn), .spi_mosi(spi_mosi),
    .spi_miso(miso1), .pulse_in(pulse_in), .led_n(led1));

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_bit(input logic b, output logic m0, output logic m1);
    spi_mosi = b;
    wait_clk(6);
    m0 = miso0;
    m1 = miso1;
    spi_clk = 1'b1;
    wait_clk(6);
    spi_clk = 1'b0;
  endtask

  task automatic xfer(input int nbits, input logic [7:0] tx,
                      output logic [63:0] r0, output logic [63:0] r1);
    logic m0, m1, b;
    r0 = '0;
    r1 = '0;
    spi_csn = 1'b0;
    wait_clk(6);
    for (int i = 0; i < nbits; i++) begin
      b = (i < 8) ? tx[7-i] : 1'b0;
      spi_bit(b, m0, m1);
      r0 = {r0[62:0], m0};
      r1 = {r1[62:0], m1};
    end
    wait_clk(4);
    spi_csn = 1'b1;
    wait_clk(8);
  endtask

  task automatic pulse(input int ch);
    pulse_in[ch] = 1'b1;
    wait_clk(7);
    pulse_in[ch] = 1'b0;
    wait_clk(7);
  endtask

  task automatic test_reset();
    logic [63:0] r0, r1;
    rst = 1'b1;
    wait_clk(4);
    total++; if (led0 !== 2'b11) begin bad++; $display("FAIL reset_led0 got=%b exp=11", led0); end
    total++; if (led1 !== 2'b11) begin bad++; $display("FAIL reset_led1 got=%b exp=11", led1); end
    total++; if (miso0 !== 1'b0) begin bad++; $display("FAIL reset_miso0 got=%b exp=0", miso0); end
    total++; if (miso1 !== 1'b0) begin bad++; $display("FAIL reset_miso1 got=%b exp=0", miso1); end
    rst = 1'b0;
    wait_clk(10);
    xfer(FL, 8'h00, r0, r1);
    total++; if (r0 !== 64'h0) begin bad++; $display("FAIL reset_frame0 got=%h exp=0", r0); end
    total++; if (r1 !== 64'h0) begin bad++; $display("FAIL reset_frame1 got=%h exp=0", r1); end
  endtask

  task automatic test_count();
    logic [63:0] r0, r1, exp;
    for (int i = 0; i < 5; i++) pulse(2);
    wait_clk(4);
    exp = 64'd5 << (FL - 24);
    xfer(FL, 8'h00, r0, r1);
    total++; if (r0 !== exp) begin bad++; $display("FAIL count5_dut0 got=%h exp=%h", r0, exp); end
    total++; if (r1 !== exp) begin bad++; $display("FAIL count5_dut1 got=%h exp=%h", r1, exp); end
    xfer(FL, 8'h00, r0, r1);
    total++; if (r0 !== 64'h0) begin bad++; $display("FAIL reread0 got=%h exp=0", r0); end
    total++; if (r1 !== 64'h0) begin bad++; $display("FAIL reread1 got=%h exp=0", r1); end
  endtask

  task automatic test_glitch();
    logic [63:0] r0, r1;
    pulse_in[1] = 1'b1;
    wait_clk(2);
    pulse_in[1] = 1'b0;
    wait_clk(12);
    xfer(FL, 8'h00, r0, r1);
    total++; if (r0 !== 64'h0) begin bad++; $display("FAIL glitch0 got=%h exp=0", r0); end
    total++; if (r1 !== 64'h0) begin bad++; $display("FAIL glitch1 got=%h exp=0", r1); end
  endtask

  // Raw pulse 4 clocks ahead of csn fall: accepted edge (2 sync + 4 debounce) meets sot (2 sync + 1 delay).
  task automatic test_sot_edge();
    logic [63:0] r0, r1, exp;
    wait_clk(1);
    pulse_in[0] = 1'b1;
    wait_clk(4);
    spi_csn = 1'b0;
    xfer(FL, 8'h00, r0, r1);
    total++; if (r0 !== 64'h0) begin bad++; $display("FAIL sotedge_first0 got=%h exp=0", r0); end
    total++; if (r1 !== 64'h0) begin bad++; $display("FAIL sotedge_first1 got=%h exp=0", r1); end
    pulse_in[0] = 1'b0;
    wait_clk(10);
    exp = 64'd1 << (FL - 8);
    xfer(FL, 8'h00, r0, r1);
    total++; if (r0 !== exp) begin bad++; $display("FAIL sotedge_next0 got=%h exp=%h", r0, exp); end
    total++; if (r1 !== exp) begin bad++; $display("FAIL sotedge_next1 got=%h exp=%h", r1, exp); end
  endtask

  task automatic test_ctrl();
    logic [63:0] r0, r1;
    xfer(FL, 8'h02, r0, r1);
    total++; if (led0 !== 2'b01) begin bad++; $display("FAIL ctrl02_led0 got=%b exp=01", led0); end
    total++; if (led1 !== 2'b01) begin bad++; $display("FAIL ctrl02_led1 got=%b exp=01", led1); end
    for (int i = 0; i < 4; i++) pulse(0);
    wait_clk(4);
    xfer(5, 8'hFF, r0, r1);
    total++; if (led0 !== 2'b01) begin bad++; $display("FAIL short_led0 got=%b exp=01", led0); end
    total++; if (r0 !== 64'h0) begin bad++; $display("FAIL short_bits0 got=%h exp=0", r0); end
    total++; if (miso0 !== 1'b0) begin bad++; $display("FAIL idle_miso0 got=%b exp=0", miso0); end
    total++; if (miso1 !== 1'b0) begin bad++; $display("FAIL idle_miso1 got=%b exp=0", miso1); end
    xfer(FL, 8'h01, r0, r1);
    total++; if (led0 !== 2'b10) begin bad++; $display("FAIL ctrl01_led0 got=%b exp=10", led0); end
    total++; if (r0 !== 64'h0) begin bad++; $display("FAIL ctrl01_frame got=%h exp=0", r0); end
  endtask

  task automatic test_overflow();
    logic [63:0] r0, r1, e0, e1;
    for (int i = 0; i < 257; i++) pulse(3);
    wait_clk(4);
    e0 = (64'd1 << (FL - 32)) | OVF3;
    e1 = (64'd255 << (FL - 32)) | OVF3;
    xfer(FL, 8'h00, r0, r1);
    total++; if (r0 !== e0) begin bad++; $display("FAIL wrap_dut0 got=%h exp=%h", r0, e0); end
    total++; if (r1 !== e1) begin bad++; $display("FAIL sat_dut1 got=%h exp=%h", r1, e1); end
    xfer(FL, 8'h00, r0, r1);
    total++; if (r0 !== 64'h0) begin bad++; $display("FAIL ovf_clear0 got=%h exp=0", r0); end
    total++; if (r1 !== 64'h0) begin bad++; $display("FAIL ovf_clear1 got=%h exp=0", r1); end
  endtask

  task automatic test_rst_mid();
    logic [63:0] r0, r1, exp;
    logic m0, m1;
    pulse(1);
    pulse(1);
    wait_clk(4);
    r0 = '0;
    r1 = '0;
    spi_csn = 1'b0;
    wait_clk(6);
    for (int i = 0; i < FL; i++) begin
      if (i == 12) begin
        rst = 1'b1;
        wait_clk(3);
        rst = 1'b0;
      end
      spi_bit(1'b1, m0, m1);
      r0 = {r0[62:0], m0};
      r1 = {r1[62:0], m1};
    end
    wait_clk(4);
    spi_csn = 1'b1;
    wait_clk(8);
    total++; if (r0 !== 64'h0) begin bad++; $display("FAIL rstmid_frame0 got=%h exp=0", r0); end
    total++; if (r1 !== 64'h0) begin bad++; $display("FAIL rstmid_frame1 got=%h exp=0", r1); end
    total++; if (led0 !== 2'b11) begin bad++; $display("FAIL rstmid_led0 got=%b exp=11", led0); end
    total++; if (led1 !== 2'b11) begin bad++; $display("FAIL rstmid_led1 got=%b exp=11", led1); end
    pulse(1);
    wait_clk(4);
    exp = 64'd1 << (FL - 16);
    xfer(FL, 8'h00, r0, r1);
    total++; if (r0 !== exp) begin bad++; $display("FAIL rstmid_restart0 got=%h exp=%h", r0, exp); end
    total++; if (r1 !== exp) begin bad++; $display("FAIL rstmid_restart1 got=%h exp=%h", r1, exp); end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_count();
    test_glitch();
    test_sot_edge();
    test_ctrl();
    test_overflow();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
